// File: rtl/esc_pwm_monitor_if.sv
// Status and pin bundle for one ESC PWM loopback monitor.
// ESC_MON_WIDTH_OUT_EN adds the raw pulse_width_us debug signal.
`timescale 1ns/1ps
interface esc_pwm_monitor_if;
  logic        pwm_in;
  logic [7:0]  rate_out;
  logic        rate_valid;
  logic        glitch_err;
  logic        signal_lost;
`ifdef ESC_MON_WIDTH_OUT_EN
  logic [15:0] pulse_width_us;

  modport master (
    output pwm_in,
    input  rate_out, rate_valid, glitch_err, signal_lost, pulse_width_us
  );
  modport slave (
    input  pwm_in,
    output rate_out, rate_valid, glitch_err, signal_lost, pulse_width_us
  );
`else
  modport master (
    output pwm_in,
    input  rate_out, rate_valid, glitch_err, signal_lost
  );
  modport slave (
    input  pwm_in,
    output rate_out, rate_valid, glitch_err, signal_lost
  );
`endif
endinterface

// File: rtl/esc_pwm_monitor.sv
// Loopback decoder for one ESC PWM line: measures pulse high time and maps it to a 0-250 rate.
// ESC_MON_WIDTH_OUT_EN enables the pulse_width_us debug register.
`timescale 1ns/1ps
module esc_pwm_monitor #(
  parameter int unsigned MIN_PULSE_US     = 1000,
  parameter int unsigned STEP_SHIFT       = 2,
  parameter int unsigned MAX_RATE         = 250,
  parameter int unsigned MIN_VALID_US     = 800,
  parameter int unsigned MAX_VALID_US     = 2200,
  parameter int unsigned FRAME_TIMEOUT_US = 25000
) (
  input logic              us_clk,
  input logic              reset,
  esc_pwm_monitor_if.slave mon
);

  localparam int unsigned WdW = $clog2(FRAME_TIMEOUT_US + 1);

  typedef enum logic [1:0] {StArm, StWaitRise, StHigh, StEval} state_e;

  state_e           state_q;
  logic             sync_q;
  logic             pwm_s_q;
  logic             pwm_d_q;
  logic [1:0]       settle_q;
  logic [15:0]      width_q;
  logic [WdW-1:0]   wd_q;

  logic             rise;
  logic             wd_expire;
  logic             width_ok;
  logic signed [16:0] diff;
  logic [16:0]      shifted;
  logic [7:0]       rate_dec;

  always_comb begin
    rise      = pwm_s_q & ~pwm_d_q;
    wd_expire = (state_q != StArm) && (wd_q == WdW'(FRAME_TIMEOUT_US - 1));
    width_ok  = (width_q >= 16'(MIN_VALID_US)) && (width_q <= 16'(MAX_VALID_US));
    // 17-bit signed so widths below MIN_PULSE_US go negative instead of wrapping
    diff      = $signed({1'b0, width_q}) - $signed(17'(MIN_PULSE_US));
    shifted   = 17'(diff >>> STEP_SHIFT);
    if (diff[16]) begin
      rate_dec = '0;
    end else if (shifted > 17'(MAX_RATE)) begin
      rate_dec = 8'(MAX_RATE);
    end else begin
      rate_dec = shifted[7:0];
    end
  end

  always_ff @(posedge us_clk) begin
    if (reset) begin
      sync_q          <= 1'b0;
      pwm_s_q         <= 1'b0;
      pwm_d_q         <= 1'b0;
      settle_q        <= '0;
      state_q         <= StArm;
      width_q         <= '0;
      wd_q            <= '0;
      mon.rate_out    <= '0;
      mon.rate_valid  <= 1'b0;
      mon.glitch_err  <= 1'b0;
      mon.signal_lost <= 1'b0;
`ifdef ESC_MON_WIDTH_OUT_EN
      mon.pulse_width_us <= '0;
`endif
    end else begin
      sync_q         <= mon.pwm_in;
      pwm_s_q        <= sync_q;
      pwm_d_q        <= pwm_s_q;
      // ARM must not trust pwm_s until real pin samples have replaced the reset zeros
      settle_q       <= {settle_q[0], 1'b1};
      mon.rate_valid <= 1'b0;
      mon.glitch_err <= 1'b0;

      if (state_q != StArm) begin
        if (rise) begin
          wd_q <= '0;
        end else if (wd_q < WdW'(FRAME_TIMEOUT_US)) begin
          wd_q <= wd_q + WdW'(1);
        end
      end

      // Written before the FSM so a valid pulse in EVAL overrides it
      if (wd_expire) begin
        mon.signal_lost <= 1'b1;
        mon.rate_out    <= '0;
      end

      unique case (state_q)
        StArm: begin
          if (settle_q[1] && !pwm_s_q) state_q <= StWaitRise;
        end
        StWaitRise: begin
          if (rise) begin
            width_q <= 16'd1;
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (pwm_s_q) begin
            if (width_q != 16'hFFFF) width_q <= width_q + 16'd1;
          end else begin
            state_q <= StEval;
          end
        end
        StEval: begin
          if (width_ok) begin
            mon.rate_out    <= rate_dec;
            mon.rate_valid  <= 1'b1;
            mon.signal_lost <= 1'b0;
          end else begin
            mon.glitch_err  <= 1'b1;
          end
`ifdef ESC_MON_WIDTH_OUT_EN
          mon.pulse_width_us <= width_q;
`endif
          state_q <= StWaitRise;
        end
        default: state_q <= StArm;
      endcase
    end
  end

endmodule

// File: tb/tb_esc_pwm_monitor.sv
// Directed bench for esc_pwm_monitor: table of pulse widths plus reset and watchdog sequences.
`timescale 1ns/1ps
module tb_esc_pwm_monitor;

  logic us_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 us_clk = ~us_clk;

  esc_pwm_monitor_if bus ();

  esc_pwm_monitor dut (
    .us_clk (us_clk),
    .reset  (reset),
    .mon    (bus)
  );

  typedef struct {
    int unsigned width;
    bit          exp_valid;
    logic [7:0]  exp_rate;
  } vec_t;

  vec_t vecs[13];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Pin high for exactly `width` sampling edges, then watch a 12-cycle window for strobes
  task automatic drive_pulse(input int unsigned width, output int nv, output int ng,
                             output int first);
    nv = 0; ng = 0; first = -1;
    @(negedge us_clk);
    bus.pwm_in = 1'b1;
    repeat (width) @(negedge us_clk);
    bus.pwm_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge us_clk);
      if (bus.rate_valid) begin nv++; if (first < 0) first = k; end
      if (bus.glitch_err) begin ng++; if (first < 0) first = k; end
    end
  endtask

  initial begin
    int nv, ng, first, cnt;

    vecs[0]  = '{1500, 1'b1, 8'd125};
    vecs[1]  = '{1000, 1'b1, 8'd0};
    vecs[2]  = '{900,  1'b1, 8'd0};
    vecs[3]  = '{2000, 1'b1, 8'd250};
    vecs[4]  = '{2100, 1'b1, 8'd250};
    vecs[5]  = '{1500, 1'b1, 8'd125};
    vecs[6]  = '{300,  1'b0, 8'd125};
    vecs[7]  = '{2200, 1'b1, 8'd250};
    vecs[8]  = '{2201, 1'b0, 8'd250};
    vecs[9]  = '{800,  1'b1, 8'd0};
    vecs[10] = '{799,  1'b0, 8'd0};
    vecs[11] = '{1007, 1'b1, 8'd1};
    vecs[12] = '{1500, 1'b1, 8'd125};

    bus.pwm_in = 1'b0;
    repeat (3) @(negedge us_clk);
    check("reset rate_out", bus.rate_out, 0);
    check("reset rate_valid", bus.rate_valid, 0);
    check("reset glitch_err", bus.glitch_err, 0);
    check("reset signal_lost", bus.signal_lost, 0);
`ifdef ESC_MON_WIDTH_OUT_EN
    check("reset pulse_width_us", bus.pulse_width_us, 0);
`endif
    reset = 1'b0;
    repeat (6) @(negedge us_clk);

    foreach (vecs[i]) begin
      drive_pulse(vecs[i].width, nv, ng, first);
      check($sformatf("v%0d w=%0d rate_valid count", i, vecs[i].width), nv,
            vecs[i].exp_valid ? 1 : 0);
      check($sformatf("v%0d w=%0d glitch_err count", i, vecs[i].width), ng,
            vecs[i].exp_valid ? 0 : 1);
      check($sformatf("v%0d strobe latency", i), first, 4);
      check($sformatf("v%0d rate_out", i), bus.rate_out, vecs[i].exp_rate);
`ifdef ESC_MON_WIDTH_OUT_EN
      check($sformatf("v%0d pulse_width_us", i), bus.pulse_width_us, vecs[i].width);
`endif
    end

    // Watchdog: rising edge at N0, expiry visible exactly 25003 falling edges later
    cnt = 0;
    @(negedge us_clk);
    bus.pwm_in = 1'b1;
    for (int c = 1; c <= 25003; c++) begin
      @(negedge us_clk);
      if (c == 1500) bus.pwm_in = 1'b0;
      if (bus.rate_valid) cnt++;
      if (c == 25002) begin
        check("wd before expiry signal_lost", bus.signal_lost, 0);
        check("wd before expiry rate_out", bus.rate_out, 125);
      end
      if (c == 25003) begin
        check("wd expiry signal_lost", bus.signal_lost, 1);
        check("wd expiry rate_out", bus.rate_out, 0);
      end
    end
    check("wd rate_valid count", cnt, 1);
    drive_pulse(1200, nv, ng, first);
    check("recover rate_valid count", nv, 1);
    check("recover rate_out", bus.rate_out, 50);
    check("recover signal_lost", bus.signal_lost, 0);

    // Reset released with the pin already high: partial pulse must be ignored
    @(negedge us_clk);
    reset = 1'b1;
    bus.pwm_in = 1'b1;
    repeat (3) @(negedge us_clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 720; c++) begin
      @(negedge us_clk);
      if (c == 700) bus.pwm_in = 1'b0;
      if (bus.rate_valid || bus.glitch_err) cnt++;
    end
    check("partial pulse strobes", cnt, 0);
    check("after reset rate_out", bus.rate_out, 0);
    drive_pulse(1400, nv, ng, first);
    check("post-arm rate_valid count", nv, 1);
    check("post-arm rate_out", bus.rate_out, 100);

    // Reset in the middle of a pulse
    cnt = 0;
    @(negedge us_clk);
    bus.pwm_in = 1'b1;
    for (int c = 1; c <= 1512; c++) begin
      @(negedge us_clk);
      if (c == 600) reset = 1'b1;
      if (c == 602) reset = 1'b0;
      if (c == 1500) bus.pwm_in = 1'b0;
      if (bus.rate_valid || bus.glitch_err) cnt++;
    end
    check("mid-pulse reset strobes", cnt, 0);
    check("mid-pulse reset rate_out", bus.rate_out, 0);
    drive_pulse(1800, nv, ng, first);
    check("after mid reset rate_valid count", nv, 1);
    check("after mid reset rate_out", bus.rate_out, 200);
    check("after mid reset signal_lost", bus.signal_lost, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
